// File: rtl/axi4_lite_if_pkg.sv
// ----------------------------------------------------------------------------
// axi4_lite_if_pkg
// Shared AXI4-Lite definitions: the response code type used on BRESP/RRESP
// and the fixed protection value driven on AWPROT/ARPROT.
// ----------------------------------------------------------------------------
package axi4_lite_if_pkg;

  typedef enum logic [1:0] {
    AXI4_RESP_OKAY   = 2'b00,
    AXI4_RESP_EXOKAY = 2'b01,
    AXI4_RESP_SLVERR = 2'b10,
    AXI4_RESP_DECERR = 2'b11
  } axi4_resp_t;

  // Unprivileged, secure, data access.
  localparam logic [2:0] AXI4_PROT_DEFAULT = 3'b000;

endpackage : axi4_lite_if_pkg

// File: rtl/axi4_lite_if.sv
// ----------------------------------------------------------------------------
// axi4_lite_if
// AXI4-Lite signal bundle (AW, W, B, AR, R channels).
// Parameters : ADDR_W address width, DATA_W data width (WSTRB is DATA_W/8).
// Modports   : mst_port - master side (drives VALIDs, BREADY/RREADY, payload)
//              slv_port - slave side (drives READYs, B/R payload)
// ----------------------------------------------------------------------------
interface axi4_lite_if
  import axi4_lite_if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;

  logic                bvalid;
  logic                bready;
  axi4_resp_t          bresp;

  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;

  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  axi4_resp_t          rresp;

  modport mst_port (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slv_port (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );

endinterface : axi4_lite_if

// File: rtl/axi4_lite_txn_wdog.sv
// ----------------------------------------------------------------------------
// axi4_lite_txn_wdog
// Transaction watchdog. Counts cycles while active_i is high, restarting the
// count whenever kick_i marks the first cycle of a new FSM state. When the
// count reaches TIMEOUT_CYCLES the flag is set and stays set until reset.
// Ports : clk_i    clock (rising edge)
//         rst_i    synchronous active-high reset
//         kick_i   high in the first cycle of every new state
//         active_i high while the FSM is in a state that should be bounded
//         flag_o   sticky timeout flag
// ----------------------------------------------------------------------------
module axi4_lite_txn_wdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic kick_i,
  input  logic active_i,
  output logic flag_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             flag_q;

  // The first cycle of a new state already counts as one cycle spent in it,
  // so a kick loads 1 (or 0 for an unbounded state). Saturates at the limit.
  always_comb begin
    count_d = count_q;
    if (kick_i) begin
      count_d = active_i ? CNT_W'(1) : '0;
    end else if (active_i && (count_q != CNT_W'(TIMEOUT_CYCLES))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (count_d == CNT_W'(TIMEOUT_CYCLES)) begin
        flag_q <= 1'b1;
      end
    end
  end

  assign flag_o = flag_q;

endmodule : axi4_lite_txn_wdog

// File: rtl/axi4_lite_cmd_mst.sv
// ----------------------------------------------------------------------------
// axi4_lite_cmd_mst
// Converts a simple valid/ready command/response pair into single AXI4-Lite
// read or write transactions, one outstanding at a time.
// Ports : i_clk, i_sync_rst          clock and synchronous active-high reset
//         i_cmd_* / o_cmd_ready      command (we, addr, wdata, wstrb)
//         o_rsp_* / i_rsp_ready      response (rdata, resp); rdata is 0 for writes
//         o_timeout                  sticky watchdog flag
//         if_m_axi4_lite             AXI4-Lite master port
// Build option : define AXI4_LITE_CMD_MST_WDOG_EN to include the transaction
//                watchdog; otherwise o_timeout is tied low.
// ----------------------------------------------------------------------------
module axi4_lite_cmd_mst
  import axi4_lite_if_pkg::*;
#(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32,
  parameter int TIMEOUT_CYCLES           = 256
) (
  input  logic                                  i_clk,
  input  logic                                  i_sync_rst,
  input  logic                                  i_cmd_valid,
  output logic                                  o_cmd_ready,
  input  logic                                  i_cmd_we,
  input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                                  o_rsp_valid,
  input  logic                                  i_rsp_ready,
  output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                            o_rsp_resp,
  output logic                                  o_timeout,
  axi4_lite_if.mst_port                         if_m_axi4_lite
);

  if ((AXI4_LITE_DATA_BIT_WIDTH != 32) && (AXI4_LITE_DATA_BIT_WIDTH != 64)) begin : g_bad_data_width
    $error("axi4_lite_cmd_mst: AXI4_LITE_DATA_BIT_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("axi4_lite_cmd_mst: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  state_t                                state_q;
  logic                                  cmd_ready_q;
  logic                                  awvalid_q, wvalid_q, arvalid_q;
  logic                                  bready_q, rready_q;
  logic                                  rsp_valid_q;
  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   addr_q;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   wdata_q;
  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] wstrb_q;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   rsp_rdata_q;
  axi4_resp_t                            rsp_resp_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = awvalid_q & if_m_axi4_lite.awready;
  assign w_hs  = wvalid_q  & if_m_axi4_lite.wready;
  assign b_hs  = bready_q  & if_m_axi4_lite.bvalid;
  assign ar_hs = arvalid_q & if_m_axi4_lite.arready;
  assign r_hs  = rready_q  & if_m_axi4_lite.rvalid;

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= AXI4_RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          // Ready comes up one cycle after reset release or response drain.
          cmd_ready_q <= 1'b1;
          if (i_cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= i_cmd_addr;
            wdata_q     <= i_cmd_wdata;
            wstrb_q     <= i_cmd_wstrb;
            if (i_cmd_we) begin
              state_q   <= WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end

        WR: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          // Each channel is done if it handshakes now or already dropped.
          if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
            state_q  <= WR_RESP;
            bready_q <= 1'b1;
          end
        end

        WR_RESP: begin
          if (b_hs) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= if_m_axi4_lite.bresp;
            state_q     <= RSP;
          end
        end

        RD_ADDR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (r_hs) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= if_m_axi4_lite.rdata;
            rsp_resp_q  <= if_m_axi4_lite.rresp;
            state_q     <= RSP;
          end
        end

        RSP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;

  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.awaddr  = addr_q;
  assign if_m_axi4_lite.awprot  = AXI4_PROT_DEFAULT;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.wdata   = wdata_q;
  assign if_m_axi4_lite.wstrb   = wstrb_q;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.araddr  = addr_q;
  assign if_m_axi4_lite.arprot  = AXI4_PROT_DEFAULT;
  assign if_m_axi4_lite.rready  = rready_q;

`ifdef AXI4_LITE_CMD_MST_WDOG_EN
  state_t state_prev_q;
  logic   wdog_kick;
  logic   wdog_active;

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state_prev_q <= IDLE;
    end else begin
      state_prev_q <= state_q;
    end
  end

  // IDLE and RSP wait on the command side, so they are not bounded.
  assign wdog_kick   = (state_q != state_prev_q);
  assign wdog_active = (state_q != IDLE) && (state_q != RSP);

  axi4_lite_txn_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i   (i_clk),
    .rst_i   (i_sync_rst),
    .kick_i  (wdog_kick),
    .active_i(wdog_active),
    .flag_o  (o_timeout)
  );
`else
  assign o_timeout = 1'b0;
`endif

endmodule : axi4_lite_cmd_mst

// File: tb/tb_axi4_lite_cmd_mst.sv
// ----------------------------------------------------------------------------
// tb_axi4_lite_cmd_mst
// Directed bench for axi4_lite_cmd_mst with a small AXI4-Lite slave model and
// a response scoreboard. Build with AXI4_LITE_CMD_MST_WDOG_EN defined to also
// exercise the watchdog flag.
// ----------------------------------------------------------------------------
module tb_axi4_lite_cmd_mst;
  import axi4_lite_if_pkg::*;

`ifdef AXI4_LITE_CMD_MST_WDOG_EN
  localparam logic WDOG = 1'b1;
`else
  localparam logic WDOG = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout;

  axi4_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi4_lite_cmd_mst #(
    .AXI4_LITE_ADDR_BIT_WIDTH(32),
    .AXI4_LITE_DATA_BIT_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk         (clk),
    .i_sync_rst    (rst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_we      (cmd_we),
    .i_cmd_addr    (cmd_addr),
    .i_cmd_wdata   (cmd_wdata),
    .i_cmd_wstrb   (cmd_wstrb),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_rdata   (rsp_rdata),
    .o_rsp_resp    (rsp_resp),
    .o_timeout     (timeout),
    .if_m_axi4_lite(axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rsp_cnt = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];
  exp_t exp_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] mem [int unsigned];
  int          aw_wait = 0;
  bit          aw_block = 1'b0;
  bit          ar_block = 1'b0;
  int          aw_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_l, w_data_l;
  logic [3:0]  w_strb_l;
  logic        s_aw_hs, s_w_hs;
  logic [31:0] s_addr, s_data, s_cur;
  logic [3:0]  s_strb;

  assign axi.awready = !aw_block && (aw_cnt >= aw_wait);
  assign axi.wready  = 1'b1;
  assign axi.arready = !ar_block;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt     <= 0;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      axi.bvalid <= 1'b0;
      axi.rvalid <= 1'b0;
    end else begin
      s_aw_hs = axi.awvalid && axi.awready;
      s_w_hs  = axi.wvalid && axi.wready;
      if (axi.awvalid && !axi.awready) aw_cnt <= aw_cnt + 1;
      if (s_aw_hs) begin
        aw_cnt    <= 0;
        aw_addr_l <= axi.awaddr;
      end
      if (s_w_hs) begin
        w_data_l <= axi.wdata;
        w_strb_l <= axi.wstrb;
      end
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
        s_addr = s_aw_hs ? axi.awaddr : aw_addr_l;
        s_data = s_w_hs ? axi.wdata : w_data_l;
        s_strb = s_w_hs ? axi.wstrb : w_strb_l;
        if (s_addr < 32'h1000) begin
          s_cur = mem.exists(s_addr) ? mem[s_addr] : 32'h0;
          for (int b = 0; b < 4; b++) begin
            if (s_strb[b]) s_cur[8*b +: 8] = s_data[8*b +: 8];
          end
          mem[s_addr] = s_cur;
          axi.bresp <= AXI4_RESP_OKAY;
        end else begin
          axi.bresp <= AXI4_RESP_SLVERR;
        end
        axi.bvalid <= 1'b1;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
      end else begin
        if (s_aw_hs) aw_got <= 1'b1;
        if (s_w_hs)  w_got  <= 1'b1;
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        axi.rvalid <= 1'b1;
        if (axi.araddr < 32'h1000) begin
          axi.rdata <= mem.exists(axi.araddr) ? mem[axi.araddr] : 32'h0;
          axi.rresp <= AXI4_RESP_OKAY;
        end else begin
          axi.rdata <= 32'h0;
          axi.rresp <= AXI4_RESP_DECERR;
        end
      end
    end
  end

  // ---------------- response scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        $display("rsp %0d: rdata=%h resp=%0d (want %h/%0d)",
                 rsp_cnt, rsp_rdata, rsp_resp, exp_e.rdata, exp_e.resp);
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_e.rdata));
        check("rsp_resp", 64'(rsp_resp), 64'(exp_e.resp));
      end
      rsp_cnt++;
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns one tick after the acceptance edge.
  task automatic send_cmd(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    int n = 0;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      step(1);
      n++;
    end
    check("cmd_ready_seen", 64'(cmd_ready), 64'd1);
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 200) begin
      step(1);
      n++;
    end
    check("rsp_arrived", 64'(rsp_cnt >= target), 64'd1);
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic [1:0] resp);
    exp_t e;
    e.rdata = rdata;
    e.resp  = resp;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: observed=expired expected=finished");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
    rsp_ready = 1'b1;
    mem[32'h8] = 32'hCAFEF00D;

    // Reset state
    step(3);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_resp", 64'(rsp_resp), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid}), 64'd0);
    check("rst_readys", 64'({axi.bready, axi.rready}), 64'd0);
    rst = 1'b0;
    step(1);
    check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    // Zero-wait write
    push_exp(32'h0, AXI4_RESP_OKAY);
    send_cmd(1'b1, 32'h0, 32'h12345678, 4'hF);
    check("wr_awvalid_c1", 64'(axi.awvalid), 64'd1);
    check("wr_wvalid_c1", 64'(axi.wvalid), 64'd1);
    check("wr_awaddr", 64'(axi.awaddr), 64'h0);
    check("wr_wdata", 64'(axi.wdata), 64'h12345678);
    check("wr_wstrb", 64'(axi.wstrb), 64'hF);
    check("wr_awprot", 64'(axi.awprot), 64'd0);
    check("wr_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    step(1);
    check("wr_bready_c2", 64'(axi.bready), 64'd1);
    check("wr_valids_dropped", 64'({axi.awvalid, axi.wvalid}), 64'd0);
    step(1);
    check("wr_rsp_valid_c3", 64'(rsp_valid), 64'd1);
    step(1);
    check("wr_rsp_done", 64'(rsp_valid), 64'd0);
    check("wr_cmd_ready_next", 64'(cmd_ready), 64'd1);
    check("wr_rsp_cnt", 64'(rsp_cnt), 64'd1);

    // Zero-wait read of the same word
    push_exp(32'h12345678, AXI4_RESP_OKAY);
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0);
    check("rd_arvalid_c1", 64'(axi.arvalid), 64'd1);
    check("rd_araddr", 64'(axi.araddr), 64'h0);
    check("rd_arprot", 64'(axi.arprot), 64'd0);
    check("rd_no_awvalid", 64'(axi.awvalid), 64'd0);
    step(1);
    check("rd_rready_c2", 64'(axi.rready), 64'd1);
    check("rd_arvalid_dropped", 64'(axi.arvalid), 64'd0);
    step(1);
    check("rd_rsp_valid_c3", 64'(rsp_valid), 64'd1);
    step(1);
    check("rd_rsp_cnt", 64'(rsp_cnt), 64'd2);

    // W accepted three cycles before AW
    aw_wait = 3;
    push_exp(32'h0, AXI4_RESP_OKAY);
    send_cmd(1'b1, 32'h4, 32'h87654321, 4'hF);
    step(1);
    check("wfirst_wvalid_low", 64'(axi.wvalid), 64'd0);
    check("wfirst_awvalid_held", 64'(axi.awvalid), 64'd1);
    step(1);
    check("wfirst_awvalid_c2", 64'(axi.awvalid), 64'd1);
    check("wfirst_awaddr_stable", 64'(axi.awaddr), 64'h4);
    step(1);
    check("wfirst_awvalid_c3", 64'(axi.awvalid), 64'd1);
    check("wfirst_no_bready", 64'(axi.bready), 64'd0);
    step(1);
    check("wfirst_awvalid_done", 64'(axi.awvalid), 64'd0);
    check("wfirst_bready", 64'(axi.bready), 64'd1);
    aw_wait = 0;
    wait_rsp(3);
    step(4);
    check("wfirst_single_rsp", 64'(rsp_cnt), 64'd3);

    // Partial strobe write, then read it back
    push_exp(32'h0, AXI4_RESP_OKAY);
    send_cmd(1'b1, 32'h0, 32'hAABBCCDD, 4'h5);
    wait_rsp(4);
    push_exp(32'h12BB56DD, AXI4_RESP_OKAY);
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0);
    wait_rsp(5);

    // Response back-pressure
    rsp_ready = 1'b0;
    push_exp(32'h87654321, AXI4_RESP_OKAY);
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      step(1);
      n++;
    end
    check("stall_rsp_seen", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      check("stall_rsp_rdata", 64'(rsp_rdata), 64'h87654321);
      check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
      step(1);
    end
    rsp_ready = 1'b1;
    wait_rsp(6);

    // Error responses from the slave
    push_exp(32'h0, AXI4_RESP_SLVERR);
    send_cmd(1'b1, 32'h2000, 32'h55, 4'hF);
    wait_rsp(7);
    push_exp(32'h0, AXI4_RESP_DECERR);
    send_cmd(1'b0, 32'h2000, 32'h0, 4'h0);
    wait_rsp(8);

    // Reset while ARVALID is pending
    ar_block = 1'b1;
    send_cmd(1'b0, 32'h8, 32'h0, 4'h0);
    check("abort_arvalid", 64'(axi.arvalid), 64'd1);
    step(2);
    check("abort_arvalid_held", 64'(axi.arvalid), 64'd1);
    check("abort_araddr", 64'(axi.araddr), 64'h8);
    rst = 1'b1;
    step(1);
    check("abort_arvalid_cleared", 64'(axi.arvalid), 64'd0);
    check("abort_rready", 64'(axi.rready), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    ar_block = 1'b0;
    step(1);
    check("abort_cmd_ready_back", 64'(cmd_ready), 64'd1);
    step(3);
    check("abort_no_rsp", 64'(rsp_cnt), 64'd8);
    push_exp(32'hCAFEF00D, AXI4_RESP_OKAY);
    send_cmd(1'b0, 32'h8, 32'h0, 4'h0);
    wait_rsp(9);

    // AWREADY withheld: watchdog
    aw_block = 1'b1;
    push_exp(32'h0, AXI4_RESP_OKAY);
    send_cmd(1'b1, 32'hC, 32'h0BADBEEF, 4'hF);
    step(15);
    check("wdog_before_limit", 64'(timeout), 64'd0);
    step(1);
    check("wdog_at_limit", 64'(timeout), 64'(WDOG));
    step(5);
    check("wdog_held", 64'(timeout), 64'(WDOG));
    check("wdog_fsm_not_aborted", 64'(axi.awvalid), 64'd1);
    aw_block = 1'b0;
    wait_rsp(10);
    step(2);
    check("wdog_sticky", 64'(timeout), 64'(WDOG));
    rst = 1'b1;
    step(1);
    check("wdog_cleared_by_rst", 64'(timeout), 64'd0);
    rst = 1'b0;
    step(1);
    push_exp(32'h0BADBEEF, AXI4_RESP_OKAY);
    send_cmd(1'b0, 32'hC, 32'h0, 4'h0);
    wait_rsp(11);
    check("wdog_quiet_after", 64'(timeout), 64'd0);

    step(3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_axi4_lite_cmd_mst

// File: doc/axi4_lite_cmd_mst.md
AXI4_LITE_CMD_MST -- requirements
Module: axi4_lite_cmd_mst

Interface
REQ-001 SHALL have parameter AXI4_LITE_ADDR_BIT_WIDTH, default 32, address bus width.
REQ-002 SHALL have parameter AXI4_LITE_DATA_BIT_WIDTH, default 32, data bus width (32 or 64).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, watchdog limit in clock cycles (>=2).
REQ-004 SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_sync_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_cmd_valid  input  1  command present.
REQ-007 SHALL have port o_cmd_ready  output  1  command accepted when high with i_cmd_valid.
REQ-008 SHALL have port i_cmd_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port i_cmd_addr  input  AXI4_LITE_ADDR_BIT_WIDTH  target address.
REQ-010 SHALL have port i_cmd_wdata  input  AXI4_LITE_DATA_BIT_WIDTH  write data.
REQ-011 SHALL have port i_cmd_wstrb  input  AXI4_LITE_DATA_BIT_WIDTH/8  write byte strobes.
REQ-012 SHALL have port o_rsp_valid  output  1  response present.
REQ-013 SHALL have port i_rsp_ready  input  1  response consumed when high with o_rsp_valid.
REQ-014 SHALL have port o_rsp_rdata  output  AXI4_LITE_DATA_BIT_WIDTH  read data (0 for writes).
REQ-015 SHALL have port o_rsp_resp  output  2  BRESP/RRESP of the transaction.
REQ-016 SHALL have port o_timeout  output  1  sticky watchdog flag.
REQ-017 SHALL have port if_m_axi4_lite  interface  axi4_lite_if.mst_port  AXI4-Lite master port, feeding the AXI VIP slave side.

Function
REQ-018 SHALL implement FSM states IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-019 SHALL drive o_cmd_ready high only in IDLE; accept on i_cmd_valid & o_cmd_ready, registering addr/wdata/wstrb/we.
REQ-020 SHALL go IDLE->WR on accepted write, IDLE->RD_ADDR on accepted read; AWVALID/WVALID or ARVALID high the cycle after acceptance.
REQ-021 In WR, SHALL assert AWVALID and WVALID together, drop each independently on its own handshake, and enter WR_RESP once both have completed (either order, or same cycle).
REQ-022 SHALL hold AWADDR/WDATA/WSTRB/ARADDR stable while the matching VALID is high; AWPROT=ARPROT=3'b000.
REQ-023 SHALL hold BREADY high only in WR_RESP and RREADY high only in RD_DATA; on handshake capture BRESP or RDATA/RRESP and enter RSP.
REQ-024 In RSP, SHALL hold o_rsp_valid high with stable data until i_rsp_ready, then return to IDLE; next command acceptable the following cycle.
REQ-025 SHALL keep at most one transaction outstanding; minimum turnaround with zero-wait slave and i_rsp_ready=1: write 4 cycles, read 4 cycles from acceptance to o_rsp_valid handshake.
REQ-026 SHALL set o_rsp_rdata to 0 for write responses.

Reset
REQ-027 While i_sync_rst high, SHALL force state IDLE and all VALID/READY outputs, o_rsp_valid, o_rsp_resp, o_rsp_rdata, o_timeout to 0 at the next edge.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no response; o_cmd_ready rises the first cycle after i_sync_rst falls.

Configuration
REQ-029 With AXI4_LITE_CMD_MST_WDOG_EN defined, SHALL count cycles spent outside IDLE/RSP, clear on each state change, and set o_timeout (sticky until reset) when count reaches TIMEOUT_CYCLES; FSM not aborted.
REQ-030 Without AXI4_LITE_CMD_MST_WDOG_EN, SHALL omit the counter and tie o_timeout to 0.

Structure
REQ-031 SHALL take axi4_resp_t (OKAY/EXOKAY/SLVERR/DECERR) from axi4_lite_if_pkg; FSM state enum stays module-local.
REQ-032 Watchdog SHALL be sub-module axi4_lite_txn_wdog (inputs: clk, rst, kick, active; output: sticky flag).

Verification
REQ-033 Write addr 0x0, data 0x12345678, wstrb 0xF, zero-wait slave -> AW/W valid cycle after accept, o_rsp_resp=OKAY, rdata=0.
REQ-034 Read addr 0x0 after REQ-033 -> o_rsp_rdata=0x12345678, resp OKAY.
REQ-035 Slave takes W 3 cycles before AW, write 0x87654321 to 0x4 -> WVALID low after its handshake, AWVALID held, single response.
REQ-036 i_rsp_ready low 5 cycles after read of 0x4 -> o_rsp_valid/o_rsp_rdata=0x87654321 stable 5 cycles, o_cmd_ready low throughout.
REQ-037 i_sync_rst pulsed while ARVALID high -> ARVALID 0 next edge, no response, next read of 0x8 completes normally.
REQ-038 WDOG_EN, TIMEOUT_CYCLES=16, slave never asserts AWREADY -> o_timeout rises 16 cycles into WR, stays high until reset.
